// File: rtl/branch_commit_unit_if.sv
// Branch commit unit bus interface.
// Bundles the ROB-head retire handshake, the branch-queue pop port, the squash
// pulse, the frontend redirect handshake and the statistics outputs.
//   master : the branch commit unit (drives commit_ready, bq_pop, squash_*,
//            redirect_valid/pc, stat_*)
//   slave  : the surrounding core (ROB, BQ, frontend)
interface branch_commit_unit_if #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned IDW  = 6,
  parameter int unsigned CNTW = 32
);
  logic            commit_valid;
  logic            commit_is_branch;
  logic [IDW-1:0]  commit_id;
  logic [XLEN-1:0] commit_pc;
  logic            commit_ready;

  logic            bq_pop;
  logic [XLEN-1:0] bq_pcnext;
  logic            bq_taken;
  logic            bq_mispred;

  logic            squash_valid;
  logic [IDW-1:0]  squash_id;

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            redirect_ready;

  logic [CNTW-1:0] stat_branches;
  logic [CNTW-1:0] stat_mispred;

  modport master (
    input  commit_valid, commit_is_branch, commit_id, commit_pc,
    output commit_ready,
    output bq_pop,
    input  bq_pcnext, bq_taken, bq_mispred,
    output squash_valid, squash_id,
    output redirect_valid, redirect_pc,
    input  redirect_ready,
    output stat_branches, stat_mispred
  );

  modport slave (
    output commit_valid, commit_is_branch, commit_id, commit_pc,
    input  commit_ready,
    input  bq_pop,
    output bq_pcnext, bq_taken, bq_mispred,
    input  squash_valid, squash_id,
    input  redirect_valid, redirect_pc,
    output redirect_ready,
    input  stat_branches, stat_mispred
  );
endinterface

// File: rtl/branch_commit_unit.sv
// Branch commit unit.
// Retires the ROB head one instruction per cycle. When the head is a branch it
// pops the branch queue in the same cycle; a mispredicted branch produces a
// one-cycle squash pulse followed by a held frontend redirect, and retirement
// stalls until the frontend accepts the redirect. Counts committed branches and
// mispredictions (wrapping).
// Ports:
//   clk  : clock, all state on rising edge
//   rstn : synchronous active-low reset
//   bus  : branch_commit_unit_if master (retire, BQ pop, squash, redirect, stats)
module branch_commit_unit #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned IDW  = 6,
  parameter int unsigned CNTW = 32
) (
  input logic                 clk,
  input logic                 rstn,
  branch_commit_unit_if.master bus
);

  typedef enum logic [1:0] {StIdle, StSquash, StRedirect} state_e;

  state_e          state_q, state_d;
  logic [IDW-1:0]  squash_id_q, squash_id_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic [CNTW-1:0] branches_q, branches_d;
  logic [CNTW-1:0] mispred_q, mispred_d;
  logic            ready;
  logic            pop;

  // Ready is gated by rstn so nothing retires while reset is held.
  assign ready = rstn & (state_q == StIdle);
  assign pop   = ready & bus.commit_valid & bus.commit_is_branch;

  always_comb begin
    state_d       = state_q;
    squash_id_d   = squash_id_q;
    redirect_pc_d = redirect_pc_q;
    branches_d    = branches_q;
    mispred_d     = mispred_q;
    case (state_q)
      StIdle: begin
        if (pop) begin
          branches_d = branches_q + CNTW'(1);
          if (bus.bq_mispred) begin
            mispred_d     = mispred_q + CNTW'(1);
            squash_id_d   = bus.commit_id;
            // Not-taken fall-through is the sequential PC of the branch itself.
            redirect_pc_d = bus.bq_taken ? bus.bq_pcnext : bus.commit_pc + XLEN'(4);
            state_d       = StSquash;
          end
        end
      end
      StSquash:   state_d = StRedirect;
      StRedirect: if (bus.redirect_ready) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= StIdle;
      squash_id_q   <= '0;
      redirect_pc_q <= '0;
      branches_q    <= '0;
      mispred_q     <= '0;
    end else begin
      state_q       <= state_d;
      squash_id_q   <= squash_id_d;
      redirect_pc_q <= redirect_pc_d;
      branches_q    <= branches_d;
      mispred_q     <= mispred_d;
    end
  end

  assign bus.commit_ready   = ready;
  assign bus.bq_pop         = pop;
  assign bus.squash_valid   = (state_q == StSquash);
  assign bus.squash_id      = squash_id_q;
  assign bus.redirect_valid = (state_q == StRedirect);
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.stat_branches  = branches_q;
  assign bus.stat_mispred   = mispred_q;

endmodule
